// File: rtl/axi4s_to_vid_out_bd_wrapper_top.sv
// Test-pattern video timing generator with an AXI4-Lite control port.
// Produces a programmable W x H frame (htotal = W+256, vtotal = H+28)
// with registered blanking/sync flags and a selectable background pattern.
// Optional build macro: VID_SYNC_ACTIVE_LOW_EN -- when defined, vid_hsync and
// vid_vsync are driven active-low (idle high); otherwise they are active-high.
module axi4s_to_vid_out_bd_wrapper_top (
    input  logic        aclk_40MHz,
    input  logic        aresetn_0,
    input  logic [11:0] s_axi_awaddr,
    input  logic        s_axi_awvalid,
    output logic        s_axi_awready,
    input  logic [31:0] s_axi_wdata,
    input  logic [3:0]  s_axi_wstrb,
    input  logic        s_axi_wvalid,
    output logic        s_axi_wready,
    output logic [1:0]  s_axi_bresp,
    output logic        s_axi_bvalid,
    input  logic        s_axi_bready,
    input  logic [11:0] s_axi_araddr,
    input  logic        s_axi_arvalid,
    output logic        s_axi_arready,
    output logic [31:0] s_axi_rdata,
    output logic [1:0]  s_axi_rresp,
    output logic        s_axi_rvalid,
    input  logic        s_axi_rready,
    output logic [23:0] vid_data,
    output logic        vid_hblank,
    output logic        vid_vblank,
    output logic        vid_hsync,
    output logic        vid_vsync
);

    localparam logic [11:0] ADDR_CTRL = 12'h000;
    localparam logic [11:0] ADDR_H    = 12'h010;
    localparam logic [11:0] ADDR_W    = 12'h018;
    localparam logic [11:0] ADDR_BG   = 12'h020;

    typedef enum logic {IDLE, RUN} state_t;

    state_t      state_q;
    logic        wrReady_q;
    logic        bvalid_q;
    logic        arready_q;
    logic        rvalid_q;
    logic [31:0] rdata_q;
    logic        autoRestart_q;
    logic        done_q;
    logic [11:0] regH_q;
    logic [11:0] regW_q;
    logic [7:0]  regBg_q;
    logic [11:0] wLat_q;
    logic [11:0] hLat_q;
    logic [7:0]  bgLat_q;
    logic [12:0] h_q;
    logic [12:0] v_q;
    logic [12:0] barCnt_q;
    logic [2:0]  barIdx_q;
    logic [12:0] barCnt_d;
    logic [2:0]  barIdx_d;
    logic        hblank_q;
    logic        vblank_q;
    logic        hsync_q;
    logic        vsync_q;
    logic [23:0] data_q;

    logic        wrEn;
    logic        rdEn;
    logic        startReq;
    logic [31:0] rdMux;
    logic [11:0] wEff;
    logic [11:0] hEff;
    logic [12:0] wExt;
    logic [12:0] hExt;
    logic [12:0] barLast;
    logic        lineEnd;
    logic        frameEnd;
    logic        hBlankC;
    logic        vBlankC;
    logic        hSyncC;
    logic        vSyncC;
    logic [23:0] barColor;
    logic [23:0] pixC;
    logic        unusedBits;

    assign unusedBits = ^{s_axi_wdata[31:12], s_axi_wstrb[3:2]};

    assign wrEn     = wrReady_q && s_axi_awvalid && s_axi_wvalid;
    assign rdEn     = arready_q && s_axi_arvalid;
    assign startReq = wrEn && (s_axi_awaddr == ADDR_CTRL) && s_axi_wstrb[0]
                      && s_axi_wdata[0] && (state_q == IDLE);

    assign wEff = (regW_q < 12'd8) ? 12'd8 : regW_q;
    assign hEff = (regH_q == 12'd0) ? 12'd1 : regH_q;
    assign wExt = {1'b0, wLat_q};
    assign hExt = {1'b0, hLat_q};

    assign lineEnd  = (h_q == wExt + 13'd255);
    assign frameEnd = lineEnd && (v_q == hExt + 13'd27);

    assign hBlankC = (h_q >= wExt);
    assign hSyncC  = (h_q >= wExt + 13'd40) && (h_q < wExt + 13'd168);
    assign vBlankC = (v_q >= hExt);
    assign vSyncC  = (v_q >= hExt + 13'd1) && (v_q < hExt + 13'd5);

    assign barLast = {4'b0, wLat_q[11:3]} - 13'd1;

    // Bar tracker advances to the next bar every W/8 pixels; bar 7 keeps the remainder
    always_comb begin
        barCnt_d = barCnt_q + 13'd1;
        barIdx_d = barIdx_q;
        if ((barIdx_q != 3'd7) && (barCnt_q == barLast)) begin
            barCnt_d = 13'd0;
            barIdx_d = barIdx_q + 3'd1;
        end
    end

    // Colour-bar palette in the {R,B,G} byte order of vid_data
    always_comb begin
        barColor = 24'h000000;
        case (barIdx_q)
            3'd0: barColor = 24'hFFFFFF;
            3'd1: barColor = 24'hFF00FF;
            3'd2: barColor = 24'h00FFFF;
            3'd3: barColor = 24'h0000FF;
            3'd4: barColor = 24'hFFFF00;
            3'd5: barColor = 24'hFF0000;
            3'd6: barColor = 24'h00FF00;
            default: barColor = 24'h000000;
        endcase
    end

    // Pattern selection from the background ID latched at frame start
    always_comb begin
        pixC = 24'h000000;
        case (bgLat_q)
            8'd1: pixC = {h_q[7:0], h_q[7:0], h_q[7:0]};
            8'd2: pixC = {v_q[7:0], v_q[7:0], v_q[7:0]};
            8'd4: pixC = 24'hFF0000;
            8'd5: pixC = 24'h0000FF;
            8'd6: pixC = 24'h00FF00;
            8'd8: pixC = 24'hFFFFFF;
            8'd9: pixC = barColor;
            default: pixC = 24'h000000;
        endcase
    end

    // Register read multiplexer; unmapped addresses read as zero
    always_comb begin
        rdMux = 32'h0;
        case (s_axi_araddr)
            ADDR_CTRL: rdMux = {24'h0, autoRestart_q, 4'b0, (state_q == IDLE), done_q, (state_q == RUN)};
            ADDR_H:    rdMux = {20'h0, regH_q};
            ADDR_W:    rdMux = {20'h0, regW_q};
            ADDR_BG:   rdMux = {24'h0, regBg_q};
            default:   rdMux = 32'h0;
        endcase
    end

    // AXI write channel: accept address and data together, one response outstanding
    always_ff @(posedge aclk_40MHz or negedge aresetn_0) begin
        if (!aresetn_0) begin
            wrReady_q     <= 1'b0;
            bvalid_q      <= 1'b0;
            autoRestart_q <= 1'b0;
            regH_q        <= 12'd0;
            regW_q        <= 12'd0;
            regBg_q       <= 8'd0;
        end else begin
            wrReady_q <= !wrReady_q && s_axi_awvalid && s_axi_wvalid && !bvalid_q;
            if (wrEn) begin
                bvalid_q <= 1'b1;
            end else if (bvalid_q && s_axi_bready) begin
                bvalid_q <= 1'b0;
            end
            if (wrEn) begin
                case (s_axi_awaddr)
                    ADDR_CTRL: if (s_axi_wstrb[0]) autoRestart_q <= s_axi_wdata[7];
                    ADDR_H: begin
                        if (s_axi_wstrb[0]) regH_q[7:0]  <= s_axi_wdata[7:0];
                        if (s_axi_wstrb[1]) regH_q[11:8] <= s_axi_wdata[11:8];
                    end
                    ADDR_W: begin
                        if (s_axi_wstrb[0]) regW_q[7:0]  <= s_axi_wdata[7:0];
                        if (s_axi_wstrb[1]) regW_q[11:8] <= s_axi_wdata[11:8];
                    end
                    ADDR_BG: if (s_axi_wstrb[0]) regBg_q <= s_axi_wdata[7:0];
                    default: ;
                endcase
            end
        end
    end

    // AXI read channel: one read outstanding, data captured at address handshake
    always_ff @(posedge aclk_40MHz or negedge aresetn_0) begin
        if (!aresetn_0) begin
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rdata_q   <= 32'h0;
        end else begin
            arready_q <= !arready_q && s_axi_arvalid && !rvalid_q;
            if (rdEn) begin
                rvalid_q <= 1'b1;
                rdata_q  <= rdMux;
            end else if (rvalid_q && s_axi_rready) begin
                rvalid_q <= 1'b0;
            end
        end
    end

    // Frame sequencer: raster counters, geometry latch at frame start, done flag
    always_ff @(posedge aclk_40MHz or negedge aresetn_0) begin
        if (!aresetn_0) begin
            state_q  <= IDLE;
            h_q      <= 13'd0;
            v_q      <= 13'd0;
            wLat_q   <= 12'd0;
            hLat_q   <= 12'd0;
            bgLat_q  <= 8'd0;
            barCnt_q <= 13'd0;
            barIdx_q <= 3'd0;
            done_q   <= 1'b0;
        end else begin
            if (rdEn && (s_axi_araddr == ADDR_CTRL)) begin
                done_q <= 1'b0;
            end
            case (state_q)
                IDLE: begin
                    if (startReq) begin
                        state_q  <= RUN;
                        h_q      <= 13'd0;
                        v_q      <= 13'd0;
                        wLat_q   <= wEff;
                        hLat_q   <= hEff;
                        bgLat_q  <= regBg_q;
                        barCnt_q <= 13'd0;
                        barIdx_q <= 3'd0;
                    end
                end
                RUN: begin
                    if (frameEnd) begin
                        h_q      <= 13'd0;
                        v_q      <= 13'd0;
                        barCnt_q <= 13'd0;
                        barIdx_q <= 3'd0;
                        if (autoRestart_q) begin
                            wLat_q  <= wEff;
                            hLat_q  <= hEff;
                            bgLat_q <= regBg_q;
                        end else begin
                            state_q <= IDLE;
                            done_q  <= 1'b1;
                        end
                    end else if (lineEnd) begin
                        h_q      <= 13'd0;
                        v_q      <= v_q + 13'd1;
                        barCnt_q <= 13'd0;
                        barIdx_q <= 3'd0;
                    end else begin
                        h_q      <= h_q + 13'd1;
                        barCnt_q <= barCnt_d;
                        barIdx_q <= barIdx_d;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Registered video outputs, one cycle behind the raster counters
    always_ff @(posedge aclk_40MHz or negedge aresetn_0) begin
        if (!aresetn_0) begin
            hblank_q <= 1'b1;
            vblank_q <= 1'b1;
            hsync_q  <= 1'b0;
            vsync_q  <= 1'b0;
            data_q   <= 24'h0;
        end else if (state_q != RUN) begin
            hblank_q <= 1'b1;
            vblank_q <= 1'b1;
            hsync_q  <= 1'b0;
            vsync_q  <= 1'b0;
            data_q   <= 24'h0;
        end else begin
            hblank_q <= hBlankC;
            vblank_q <= vBlankC;
            hsync_q  <= hSyncC;
            vsync_q  <= vSyncC;
            data_q   <= (hBlankC || vBlankC) ? 24'h0 : pixC;
        end
    end

    assign s_axi_awready = wrReady_q;
    assign s_axi_wready  = wrReady_q;
    assign s_axi_bvalid  = bvalid_q;
    assign s_axi_bresp   = 2'b00;
    assign s_axi_arready = arready_q;
    assign s_axi_rvalid  = rvalid_q;
    assign s_axi_rdata   = rdata_q;
    assign s_axi_rresp   = 2'b00;

    assign vid_data   = data_q;
    assign vid_hblank = hblank_q;
    assign vid_vblank = vblank_q;
`ifdef VID_SYNC_ACTIVE_LOW_EN
    assign vid_hsync = ~hsync_q;
    assign vid_vsync = ~vsync_q;
`else
    assign vid_hsync = hsync_q;
    assign vid_vsync = vsync_q;
`endif

endmodule

// File: tb/tb_axi4s_to_vid_out_bd_wrapper_top.sv
// Directed bench for the video pattern generator: register access, one-shot and
// auto-restart frames, geometry clamping, mid-frame width change, reset abort.
`timescale 1ns/1ps
module tb_axi4s_to_vid_out_bd_wrapper_top;

    logic        clk = 1'b0;
    logic        rstN;
    logic [11:0] awaddr;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wvalid;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;
    logic [11:0] araddr;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready;
    logic [23:0] vidData;
    logic        vidHblank;
    logic        vidVblank;
    logic        vidHsync;
    logic        vidVsync;

    int checks = 0;
    int errors = 0;
    logic [23:0] expQ[$];

`ifdef VID_SYNC_ACTIVE_LOW_EN
    localparam bit SYNC_LOW = 1'b1;
`else
    localparam bit SYNC_LOW = 1'b0;
`endif

    logic hsAct;
    logic vsAct;
    assign hsAct = vidHsync ^ SYNC_LOW;
    assign vsAct = vidVsync ^ SYNC_LOW;

    logic [23:0] barTab [8];
    initial begin
        barTab[0] = 24'hFFFFFF; barTab[1] = 24'hFF00FF; barTab[2] = 24'h00FFFF; barTab[3] = 24'h0000FF;
        barTab[4] = 24'hFFFF00; barTab[5] = 24'hFF0000; barTab[6] = 24'h00FF00; barTab[7] = 24'h000000;
    end

    always #12.5 clk = ~clk;

    axi4s_to_vid_out_bd_wrapper_top dut (
        .aclk_40MHz    (clk),
        .aresetn_0     (rstN),
        .s_axi_awaddr  (awaddr),
        .s_axi_awvalid (awvalid),
        .s_axi_awready (awready),
        .s_axi_wdata   (wdata),
        .s_axi_wstrb   (wstrb),
        .s_axi_wvalid  (wvalid),
        .s_axi_wready  (wready),
        .s_axi_bresp   (bresp),
        .s_axi_bvalid  (bvalid),
        .s_axi_bready  (bready),
        .s_axi_araddr  (araddr),
        .s_axi_arvalid (arvalid),
        .s_axi_arready (arready),
        .s_axi_rdata   (rdata),
        .s_axi_rresp   (rresp),
        .s_axi_rvalid  (rvalid),
        .s_axi_rready  (rready),
        .vid_data      (vidData),
        .vid_hblank    (vidHblank),
        .vid_vblank    (vidVblank),
        .vid_hsync     (vidHsync),
        .vid_vsync     (vidVsync)
    );

    // One comparison: count it, and on mismatch count and report the failure
    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // An expired wait bound counts as a failed comparison
    task automatic timeoutFail(input string tag);
        checks++;
        errors++;
        $error("FAIL %s: timed out waiting for DUT", tag);
    endtask

    // AXI-Lite register write with bounded handshakes
    task automatic applyStimulus(input logic [11:0] addr, input logic [31:0] data);
        int n;
        @(negedge clk);
        awaddr = addr; awvalid = 1'b1; wdata = data; wstrb = 4'hF; wvalid = 1'b1; bready = 1'b1;
        n = 0;
        while (!awready && n < 20) begin @(negedge clk); n++; end
        if (n >= 20) begin
            timeoutFail("awready");
            awvalid = 1'b0; wvalid = 1'b0;
            return;
        end
        @(posedge clk); #1;
        awvalid = 1'b0; wvalid = 1'b0;
        n = 0;
        while (!bvalid && n < 20) begin @(negedge clk); n++; end
        if (n >= 20) begin timeoutFail("bvalid"); return; end
        checkOutput("bresp", {30'h0, bresp}, 32'h0);
        @(posedge clk); #1;
    endtask

    // AXI-Lite register read with bounded handshakes
    task automatic axiRead(input logic [11:0] addr, output logic [31:0] data, output logic [1:0] resp);
        int n;
        data = 32'hxxxxxxxx; resp = 2'bxx;
        @(negedge clk);
        araddr = addr; arvalid = 1'b1; rready = 1'b1;
        n = 0;
        while (!arready && n < 20) begin @(negedge clk); n++; end
        if (n >= 20) begin timeoutFail("arready"); arvalid = 1'b0; return; end
        @(posedge clk); #1;
        arvalid = 1'b0;
        n = 0;
        while (!rvalid && n < 20) begin @(negedge clk); n++; end
        if (n >= 20) begin timeoutFail("rvalid"); return; end
        data = rdata; resp = rresp;
        @(posedge clk); #1;
    endtask

    task automatic readCheck(input string tag, input logic [11:0] addr, input logic [31:0] exp);
        logic [31:0] d;
        logic [1:0]  r;
        axiRead(addr, d, r);
        checkOutput(tag, d, exp);
    endtask

    task automatic checkIdleOutputs(input string tag);
        checkOutput({tag, "_hblank"}, {31'h0, vidHblank}, 32'h1);
        checkOutput({tag, "_vblank"}, {31'h0, vidVblank}, 32'h1);
        checkOutput({tag, "_hsync"},  {31'h0, hsAct}, 32'h0);
        checkOutput({tag, "_vsync"},  {31'h0, vsAct}, 32'h0);
        checkOutput({tag, "_data"},   {8'h0, vidData}, 32'h0);
    endtask

    // Measure the next full line from one hblank falling edge to the next
    task automatic measureLine(output int act, output int ssStart, output int ssLen, output int len);
        logic prev;
        bit   found;
        act = 0; ssStart = -1; ssLen = 0; len = -1;
        found = 0;
        prev = vidHblank;
        for (int i = 0; i < 20000; i++) begin
            @(negedge clk);
            if (prev && !vidHblank) begin found = 1; break; end
            prev = vidHblank;
        end
        if (!found) begin timeoutFail("lineStart"); return; end
        found = 0;
        for (int i = 0; i < 10000; i++) begin
            if (!vidHblank) act++;
            if (hsAct) begin
                if (ssStart < 0) ssStart = i;
                ssLen++;
            end
            prev = vidHblank;
            @(negedge clk);
            if (prev && !vidHblank) begin len = i + 1; found = 1; break; end
        end
        if (!found) timeoutFail("lineEnd");
    endtask

    // Measure vertical timing from frame start until vsync deasserts
    task automatic measureFrame(output int vAct, output int vsStart, output int vsLen);
        logic prev;
        bit   found;
        vAct = 0; vsStart = -1; vsLen = 0;
        found = 0;
        prev = vidVblank;
        for (int i = 0; i < 30000; i++) begin
            @(negedge clk);
            if (prev && !vidVblank) begin found = 1; break; end
            prev = vidVblank;
        end
        if (!found) begin timeoutFail("frameStart"); return; end
        found = 0;
        for (int i = 0; i < 30000; i++) begin
            if (!vidVblank) vAct++;
            if (vsAct) begin
                if (vsStart < 0) vsStart = i;
                vsLen++;
            end else if (vsLen > 0) begin
                found = 1;
                break;
            end
            @(negedge clk);
        end
        if (!found) timeoutFail("vsyncEnd");
    endtask

    // Scoreboard: every active pixel pops one expected value; blanking must carry zero data
    always @(negedge clk) begin
        if (rstN) begin
            if (!vidHblank && !vidVblank) begin
                checks++;
                assert (expQ.size() != 0) else begin
                    errors++;
                    $error("FAIL unexpectedPixel: observed %0h expected no active pixel", vidData);
                end
                if (expQ.size() != 0) checkOutput("pixel", {8'h0, vidData}, {8'h0, expQ.pop_front()});
            end else begin
                checkOutput("blankData", {8'h0, vidData}, 32'h0);
            end
        end
    end

    task automatic pushBars(input int w, input int rows);
        int idx;
        for (int r = 0; r < rows; r++)
            for (int h = 0; h < w; h++) begin
                idx = h / (w / 8);
                if (idx > 7) idx = 7;
                expQ.push_back(barTab[idx]);
            end
    endtask

    initial begin
        int act, ssStart, ssLen, len, vAct, vsStart, vsLen;
        logic [31:0] d;
        logic [1:0]  r;
        logic [7:0]  hb;

        rstN = 1'b0;
        awaddr = '0; awvalid = 1'b0; wdata = '0; wstrb = '0; wvalid = 1'b0; bready = 1'b0;
        araddr = '0; arvalid = 1'b0; rready = 1'b0;
        repeat (5) @(negedge clk);
        $display("[TB] reset state");
        checkIdleOutputs("reset");
        checkOutput("reset_awready", {31'h0, awready}, 32'h0);
        checkOutput("reset_arready", {31'h0, arready}, 32'h0);
        checkOutput("reset_bvalid",  {31'h0, bvalid}, 32'h0);
        checkOutput("reset_rvalid",  {31'h0, rvalid}, 32'h0);
        rstN = 1'b1;
        repeat (3) @(negedge clk);
        readCheck("ctrlReset", 12'h000, 32'h04);
        readCheck("hReset",    12'h010, 32'h0);
        readCheck("wReset",    12'h018, 32'h0);
        readCheck("bgReset",   12'h020, 32'h0);
        axiRead(12'h044, d, r);
        checkOutput("unmappedData", d, 32'h0);
        checkOutput("unmappedResp", {30'h0, r}, 32'h0);

        $display("[TB] one-shot 16x4 red frame");
        applyStimulus(12'h018, 32'd16);
        applyStimulus(12'h010, 32'd4);
        applyStimulus(12'h020, 32'd4);
        readCheck("wReadback", 12'h018, 32'd16);
        for (int i = 0; i < 64; i++) expQ.push_back(24'hFF0000);
        applyStimulus(12'h000, 32'h01);
        repeat (8800) @(negedge clk);
        checkOutput("redQueueDrained", expQ.size(), 32'd0);
        checkIdleOutputs("afterOneShot");
        readCheck("ctrlDone", 12'h000, 32'h06);
        readCheck("ctrlDoneCleared", 12'h000, 32'h04);

        $display("[TB] clamped geometry with horizontal ramp");
        applyStimulus(12'h018, 32'd3);
        applyStimulus(12'h010, 32'd0);
        applyStimulus(12'h020, 32'd1);
        readCheck("wRawReadback", 12'h018, 32'd3);
        for (int h = 0; h < 8; h++) begin
            hb = 8'(h);
            expQ.push_back({hb, hb, hb});
        end
        applyStimulus(12'h000, 32'h01);
        measureLine(act, ssStart, ssLen, len);
        checkOutput("clampActive", act, 32'd8);
        checkOutput("clampLineLen", len, 32'd264);
        repeat (7300) @(negedge clk);
        checkOutput("rampQueueDrained", expQ.size(), 32'd0);
        readCheck("ctrlClampDone", 12'h000, 32'h06);

        $display("[TB] colour bars with mid-frame width change");
        applyStimulus(12'h018, 32'd36);
        applyStimulus(12'h010, 32'd2);
        applyStimulus(12'h020, 32'd9);
        pushBars(36, 2);
        pushBars(20, 2);
        applyStimulus(12'h000, 32'h81);
        measureLine(act, ssStart, ssLen, len);
        checkOutput("f1Active", act, 32'd36);
        checkOutput("f1SyncStart", ssStart, 32'd76);
        checkOutput("f1SyncLen", ssLen, 32'd128);
        checkOutput("f1LineLen", len, 32'd292);
        applyStimulus(12'h018, 32'd20);
        measureFrame(vAct, vsStart, vsLen);
        checkOutput("f2VActive", vAct, 32'd552);
        checkOutput("f2VsyncStart", vsStart, 32'd828);
        checkOutput("f2VsyncLen", vsLen, 32'd1104);
        applyStimulus(12'h000, 32'h00);
        measureLine(act, ssStart, ssLen, len);
        checkOutput("f2Active", act, 32'd20);
        checkOutput("f2SyncStart", ssStart, 32'd60);
        checkOutput("f2SyncLen", ssLen, 32'd128);
        checkOutput("f2LineLen", len, 32'd276);
        repeat (6200) @(negedge clk);
        checkOutput("barsQueueDrained", expQ.size(), 32'd0);
        checkIdleOutputs("afterAutoStop");
        readCheck("ctrlAutoStopped", 12'h000, 32'h06);

        $display("[TB] 800x600 bars, then reset mid-line");
        applyStimulus(12'h018, 32'd800);
        applyStimulus(12'h010, 32'd600);
        pushBars(800, 4);
        applyStimulus(12'h000, 32'h81);
        readCheck("ctrlRunning", 12'h000, 32'h81);
        measureLine(act, ssStart, ssLen, len);
        checkOutput("svgaActive", act, 32'd800);
        checkOutput("svgaSyncStart", ssStart, 32'd840);
        checkOutput("svgaSyncLen", ssLen, 32'd128);
        checkOutput("svgaLineLen", len, 32'd1056);
        repeat (900) @(negedge clk);
        checkOutput("svgaQueueLeft", expQ.size(), 32'd800);
        repeat (556) @(negedge clk);
        checkOutput("svgaActiveBeforeReset", {31'h0, vidHblank}, 32'h0);
        #3 rstN = 1'b0;
        #1;
        checkIdleOutputs("asyncReset");
        expQ.delete();
        repeat (3) @(negedge clk);
        rstN = 1'b1;
        readCheck("ctrlAfterReset", 12'h000, 32'h04);
        readCheck("wAfterReset", 12'h018, 32'h0);
        checkIdleOutputs("idleAfterReset");

        $display("[TB] unsupported pattern ID gives black active video");
        applyStimulus(12'h018, 32'd8);
        applyStimulus(12'h010, 32'd1);
        applyStimulus(12'h020, 32'd3);
        for (int i = 0; i < 8; i++) expQ.push_back(24'h000000);
        applyStimulus(12'h000, 32'h81);
        measureLine(act, ssStart, ssLen, len);
        checkOutput("bg3Active", act, 32'd8);
        checkOutput("bg3LineLen", len, 32'd264);
        checkOutput("bg3QueueDrained", expQ.size(), 32'd0);
        @(negedge clk);
        rstN = 1'b0;
        repeat (3) @(negedge clk);
        rstN = 1'b1;
        act = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (!vidVblank) act++;
        end
        checkOutput("noRestartAfterReset", act, 32'd0);
        readCheck("ctrlFinal", 12'h000, 32'h04);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
